// File: rtl/ice_fifo_pkg.sv
// Shared definitions for the ICE/MBus frame FIFO: FSM encoding, EOF flag position, defaults.
package ice_fifo_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int DEPTH_LOG2_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } fifo_state_e;

    // The EOF flag sits directly above the payload in every stored word.
    function automatic int eof_pos(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/msg_frame_fifo_ram.sv
// Inferred frame storage: two write ports (data word and EOF marker) and one read port on a registered address.
module ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[waddr_a] <= wdata_a;
        if (we_b) mem[waddr_b] <= wdata_b;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/msg_frame_fifo.sv
// Framed message FIFO with atomic drop of overflowing frames and an in-band EOF marker per frame.
// Define MSG_FRAME_FIFO_LEN_EN to carry the frame length (mod 2**DATA_W) in the marker payload.
module msg_frame_fifo
    import ice_fifo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_data_latch,
    input  logic                  in_frame_valid,
    output logic                  in_full,
    output logic                  in_data_overflow,
    output logic [DEPTH_LOG2-1:0] tail,
    input  logic [DEPTH_LOG2-1:0] out_data_addr,
    output logic [DATA_W:0]       out_data,
    output logic                  out_frame_valid,
    output logic [DEPTH_LOG2-1:0] out_frame_count,
    output logic                  out_frame_data_valid,
    input  logic                  latch_tail
);

    localparam int WORD_W  = DATA_W + 1;
    localparam int EOF_BIT = eof_pos(DATA_W);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    fifo_state_e       state_q, state_d;
    ptr_t              head_q, head_d, tail_q, tail_d, start_q, start_d;
    ptr_t              count_q, count_d, raddr_q, raddr_d, mark_addr;
    logic              last_fv_q, last_fv_d, ovf_q, ovf_d;
    logic              rise, fall, full, two_free;
    logic              data_wr, mark_wr, commit, release_ok;
    logic [DATA_W-1:0] mark_pay;
    logic [WORD_W-1:0] data_word, mark_word;

    assign rise     = in_frame_valid & ~last_fv_q;
    assign fall     = ~in_frame_valid & last_fv_q;
    assign full     = (head_q + PTR_ONE) == tail_q;
    assign two_free = !full && ((head_q + ptr_t'(2)) != tail_q);

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        start_d   = start_q;
        data_wr   = 1'b0;
        mark_wr   = 1'b0;
        mark_addr = head_q;
        commit    = 1'b0;
        ovf_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_FILL;
                    start_d = head_q;
                    if (in_data_latch) begin
                        if (!full) begin
                            data_wr = 1'b1;
                            head_d  = head_q + PTR_ONE;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_FILL: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    // A word arriving with the fall needs room for itself and the marker.
                    if (in_data_latch ? two_free : !full) begin
                        data_wr   = in_data_latch;
                        mark_wr   = 1'b1;
                        mark_addr = in_data_latch ? head_q + PTR_ONE : head_q;
                        head_d    = mark_addr + PTR_ONE;
                        commit    = 1'b1;
                    end else begin
                        head_d = start_q;
                        ovf_d  = 1'b1;
                    end
                end else if (in_data_latch) begin
                    if (!full) begin
                        data_wr = 1'b1;
                        head_d  = head_q + PTR_ONE;
                    end else begin
                        head_d  = start_q;
                        ovf_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (fall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MSG_FRAME_FIFO_LEN_EN
    localparam logic [DATA_W-1:0] LEN_ONE = 1;
    logic [DATA_W-1:0] len_q, len_d;

    always_comb begin
        len_d = (state_q == ST_IDLE) ? '0 : len_q;
        if (data_wr) len_d = len_d + LEN_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) len_q <= '0;
        else     len_q <= len_d;
    end

    // len_d already includes a data word written alongside the marker.
    assign mark_pay = len_d;
`else
    assign mark_pay = '0;
`endif

    always_comb begin
        data_word = {1'b0, in_data};
        mark_word = {1'b0, mark_pay};
        mark_word[EOF_BIT] = 1'b1;
    end

    assign release_ok = latch_tail && (count_q != '0);

    always_comb begin
        count_d   = count_q;
        tail_d    = release_ok ? out_data_addr : tail_q;
        last_fv_d = in_frame_valid;
        raddr_d   = out_data_addr;
        if (commit && !release_ok)      count_d = count_q + PTR_ONE;
        else if (!commit && release_ok) count_d = count_q - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            start_q   <= '0;
            count_q   <= '0;
            raddr_q   <= '0;
            last_fv_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            start_q   <= start_d;
            count_q   <= count_d;
            raddr_q   <= raddr_d;
            last_fv_q <= last_fv_d;
            ovf_q     <= ovf_d;
        end
    end

    ram #(WORD_W, DEPTH_LOG2) u_ram (
        .clk     (clk),
        .we_a    (data_wr & ~rst),
        .waddr_a (head_q),
        .wdata_a (data_word),
        .we_b    (mark_wr & ~rst),
        .waddr_b (mark_addr),
        .wdata_b (mark_word),
        .raddr   (raddr_q),
        .rdata   (out_data)
    );

    assign in_full              = full;
    assign in_data_overflow     = ovf_q;
    assign tail                 = tail_q;
    assign out_frame_count      = count_q;
    assign out_frame_valid      = count_q != '0;
    assign out_frame_data_valid = out_data_addr == raddr_q;

endmodule

// File: tb/tb_msg_frame_fifo.sv
// Bench for msg_frame_fifo: frame-level reference model (free-slot arithmetic, frame queue) with directed and random frames.
module tb_msg_frame_fifo;
    import ice_fifo_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int WW = DW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_data_latch = 1'b0;
    logic          in_frame_valid = 1'b0;
    logic          in_full;
    logic          in_data_overflow;
    logic [AW-1:0] tail;
    logic [AW-1:0] out_data_addr = '0;
    logic [WW-1:0] out_data;
    logic          out_frame_valid;
    logic [AW-1:0] out_frame_count;
    logic          out_frame_data_valid;
    logic          latch_tail = 1'b0;

    msg_frame_fifo #(.DATA_W(DW), .DEPTH_LOG2(AW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_data              (in_data),
        .in_data_latch        (in_data_latch),
        .in_frame_valid       (in_frame_valid),
        .in_full              (in_full),
        .in_data_overflow     (in_data_overflow),
        .tail                 (tail),
        .out_data_addr        (out_data_addr),
        .out_data             (out_data),
        .out_frame_valid      (out_frame_valid),
        .out_frame_count      (out_frame_count),
        .out_frame_data_valid (out_frame_data_valid),
        .latch_tail           (latch_tail)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [WW-1:0] m_mem [D];
    bit            m_wr [D];
    int            m_head = 0;
    int            m_tail = 0;
    int            m_count = 0;
    int            m_fq[$];
    logic [DW-1:0] fixed_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_free();
        return (m_tail - m_head - 1 + 2 * D) % D;
    endfunction

    function automatic logic [WW-1:0] marker(input int n);
        logic [DW-1:0] p;
`ifdef MSG_FRAME_FIFO_LEN_EN
        p = DW'(n);
`else
        p = '0;
`endif
        return {1'b1, p};
    endfunction

    task automatic m_put(input int a, input logic [WW-1:0] w);
        m_mem[a % D] = w;
        m_wr[a % D]  = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(out_frame_count), 32'(m_count));
        chk({tag, ".fvalid"}, 32'(out_frame_valid), 32'(m_count != 0));
        chk({tag, ".tail"}, 32'(tail), 32'(m_tail));
        chk({tag, ".head"}, 32'(dut.head_q), 32'(m_head));
        chk({tag, ".full"}, 32'(in_full), 32'(((m_head + 1) % D) == m_tail));
        chk({tag, ".state"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_frame_valid = 1'b0;
        in_data_latch = 1'b0;
        latch_tail = 1'b0;
        tick();
        rst = 1'b0;
        m_head = 0;
        m_tail = 0;
        m_count = 0;
        m_fq.delete();
    endtask

    // One whole frame; overflow pulses are tagged with the number of latches issued so far.
    task automatic drive_frame(input int n, input bit coinc, input bit rel_fall, input int rel_addr);
        int            free = m_free();
        int            ovf_cnt = 0;
        int            ovf_tag = -1;
        int            latches = 0;
        int            nw;
        bit            commit;
        bit            rel_ok;
        logic [DW-1:0] wq[$];
        if (n == 0) begin
            in_frame_valid = 1'b1;
            in_data_latch = 1'b0;
            tick();
            if (in_data_overflow) begin ovf_cnt++; ovf_tag = latches; end
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                in_frame_valid = 1'b1;
                in_data_latch = 1'b0;
                tick();
                if (in_data_overflow) begin ovf_cnt++; ovf_tag = latches; end
            end
            in_frame_valid = !(coinc && i == n - 1);
            in_data_latch = 1'b1;
            if (fixed_q.size() > 0) in_data = fixed_q.pop_front();
            else                    in_data = DW'($urandom);
            wq.push_back(in_data);
            if (!in_frame_valid && rel_fall) begin
                latch_tail = 1'b1;
                out_data_addr = AW'(rel_addr);
            end
            tick();
            latches++;
            if (in_data_overflow) begin ovf_cnt++; ovf_tag = latches; end
        end
        if (!coinc) begin
            in_frame_valid = 1'b0;
            in_data_latch = 1'b0;
            if (rel_fall) begin
                latch_tail = 1'b1;
                out_data_addr = AW'(rel_addr);
            end
            tick();
            if (in_data_overflow) begin ovf_cnt++; ovf_tag = latches; end
        end
        in_frame_valid = 1'b0;
        in_data_latch = 1'b0;
        latch_tail = 1'b0;

        commit = (n <= free - 1);
        rel_ok = rel_fall && (m_count > 0);
        if (commit) begin
            for (int i = 0; i < n; i++) m_put(m_head + i, {1'b0, wq[i]});
            m_put(m_head + n, marker(n));
            m_fq.push_back((m_head + n) % D);
            m_head = (m_head + n + 1) % D;
        end else begin
            nw = (n > free) ? free : (coinc ? n - 1 : n);
            for (int i = 0; i < nw; i++) m_put(m_head + i, {1'b0, wq[i]});
        end
        if (rel_ok) begin
            m_tail = rel_addr % D;
            m_count--;
            void'(m_fq.pop_front());
        end
        if (commit) m_count++;

        chk("frame.ovf_pulses", 32'(ovf_cnt), commit ? 32'd0 : 32'd1);
        if (!commit) chk("frame.ovf_at_latch", 32'(ovf_tag), 32'((n > free) ? free + 1 : n));
        check_state("frame");
    endtask

    task automatic rd(input int a);
        logic [AW-1:0] prev;
        prev = out_data_addr;
        out_data_addr = AW'(a);
        #1;
        if (AW'(a) != prev) chk("rd.dvalid_low", 32'(out_frame_data_valid), 32'd0);
        tick();
        chk("rd.dvalid_high", 32'(out_frame_data_valid), 32'd1);
        if (m_wr[a % D]) chk($sformatf("rd.data@%0d", a % D), 32'(out_data), 32'(m_mem[a % D]));
    endtask

    task automatic rel(input int a);
        out_data_addr = AW'(a);
        latch_tail = 1'b1;
        tick();
        latch_tail = 1'b0;
        if (m_count > 0) begin
            m_tail = a % D;
            m_count--;
            void'(m_fq.pop_front());
        end
        check_state("release");
    endtask

    task automatic read_oldest();
        int a;
        int e;
        if (m_fq.size() > 0) begin
            a = m_tail;
            e = m_fq[0];
            for (int k = 0; k < D; k++) begin
                rd(a);
                if (a == e) break;
                a = (a + 1) % D;
            end
            rel((e + 1) % D);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] exp_a3;
        int n;
`ifdef MSG_FRAME_FIFO_LEN_EN
        exp_a3 = 9'h103;
`else
        exp_a3 = 9'h100;
`endif
        tick();
        do_reset();
        check_state("reset");
        chk("reset.ovf", 32'(in_data_overflow), 32'd0);
        chk("reset.dvalid", 32'(out_frame_data_valid), 32'd1);

        // Data latched with no frame open is ignored.
        in_data = 8'h55;
        in_data_latch = 1'b1;
        tick();
        in_data_latch = 1'b0;
        check_state("idle_latch");
        chk("idle_latch.ovf", 32'(in_data_overflow), 32'd0);

        fixed_q = '{8'hA1, 8'hA2, 8'hA3};
        drive_frame(3, 1'b0, 1'b0, 0);
        for (int a = 0; a < 4; a++) rd(a);
        chk("frameA.marker", 32'(out_data), 32'(exp_a3));

        drive_frame(0, 1'b0, 1'b0, 0);
        rd(4);
        chk("zero.marker", 32'(out_data), 32'h100);
        read_oldest();
        read_oldest();

        // Overflow with DEPTH 16: the 16th latch cannot fit.
        do_reset();
        drive_frame(20, 1'b0, 1'b0, 0);
        drive_frame(3, 1'b0, 1'b0, 0);
        rd(0);
        rd(3);

        // Commit and release on the same cycle.
        drive_frame(2, 1'b0, 1'b1, 4);
        read_oldest();

        // Release with nothing committed, then a fresh read address.
        rel(2);
        rd(5);

        drive_frame(3, 1'b1, 1'b0, 0);
        read_oldest();

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    n = $urandom_range(0, 10);
                    drive_frame(n, (n >= 2) && ($urandom_range(0, 1) == 1), 1'b0, 0);
                end
                2: read_oldest();
                default: begin
                    in_data = DW'($urandom);
                    in_data_latch = 1'b1;
                    tick();
                    in_data_latch = 1'b0;
                    check_state("rand_idle_latch");
                end
            endcase
        end

        // Reset in the middle of a frame.
        do_reset();
        in_frame_valid = 1'b1;
        in_data_latch = 1'b1;
        in_data = DW'($urandom);
        m_put(0, {1'b0, in_data});
        tick();
        in_data = DW'($urandom);
        m_put(1, {1'b0, in_data});
        tick();
        rst = 1'b1;
        in_frame_valid = 1'b0;
        in_data_latch = 1'b0;
        tick();
        rst = 1'b0;
        m_head = 0;
        m_tail = 0;
        m_count = 0;
        m_fq.delete();
        check_state("midrst");
        drive_frame(2, 1'b0, 1'b0, 0);
        for (int a = 0; a < 3; a++) rd(a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
